titan_mem_arbiter: RTL and testbench
====================================

Name: titan_mem_arbiter

Overview:
- Two-requester arbiter sharing the single BRAM port between instruction fetch (read-only) and the LSU data port (read/write).
- Grants one transaction at a time and drives the shared memory bus from registered, latched copies of the winner's request.
- Routes ack, read data and a bus-timeout error back to the winner.
- Sits between the core front-end/LSU and the BRAM.

Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width; byte-select width is DATA_W/8
- TIMEOUT, 255, cycles in BUSY without m_ack before error; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset (asserted when 0)
- i_req  in  1  fetch request, held until i_ack or i_err
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data, valid with i_ack
- i_ack  out  1  fetch completion pulse
- i_err  out  1  fetch timeout pulse
- d_req  in  1  data request, held until d_ack or d_err
- d_we  in  1  1 = store, 0 = load
- d_sel  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  data completion pulse
- d_err  out  1  data timeout pulse
- m_cyc  out  1  memory request active
- m_we  out  1  memory write enable
- m_sel  out  DATA_W/8  memory byte enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- m_ack  in  1  memory completion, single-cycle pulse

Behaviour:
- Reset (rst == 0 at posedge):
  - State = IDLE; last_grant = I.
  - m_cyc, m_we, i_ack, i_err, d_ack, d_err = 0.
  - m_addr, m_wdata, m_sel, i_rdata, d_rdata = 0.
  - Timeout counter = 0.
  - Reset mid-transaction aborts it with no ack/err; a later m_ack is ignored.
- States:
  - IDLE: no transaction open.
  - BUSY_I: fetch transaction open.
  - BUSY_D: data transaction open.
- IDLE arbitration, evaluated each posedge:
  - Only d_req: grant D.
  - Only i_req: grant I.
  - Both: grant the requester other than last_grant (round-robin), so D wins the first contention after reset.
- On grant (registered):
  - Latch winner's addr, sel (fetch uses all-ones) and wdata into m_* registers.
  - m_we = d_we for D, 0 for I.
  - m_cyc = 1; last_grant updated; counter cleared; enter BUSY_x.
  - First cycle with m_cyc = 1 is the cycle after the grant edge.
- BUSY_x, m_ack = 1:
  - Next edge: x_ack = 1 for exactly one cycle; x_rdata = m_rdata (registered).
  - m_cyc = 0, m_we = 0; return to IDLE.
- Latency: request seen in IDLE -> m_cyc next cycle -> x_ack one cycle after m_ack.
- Minimum 1-cycle IDLE gap after every ack/err, so a requester may drop req on the edge after its ack without being re-granted.
- A req still high during the IDLE gap is treated as a new request.
- Requester inputs may change while BUSY; the arbiter uses latched copies only.
- Timeout (TIMEOUT > 0):
  - Counter increments each BUSY cycle without m_ack.
  - When it reaches TIMEOUT - 1 with m_ack still 0: next edge x_err = 1 for one cycle; m_cyc = 0; IDLE; no ack.
  - m_ack in the same cycle as the expiry wins: ack, not err.
  - m_ack arriving in IDLE is ignored.
- The non-granted request is not dropped; it stays pending and wins at the next IDLE edge if still asserted.
- Counter width = clog2(TIMEOUT + 1), minimum 1.

Decomposition:
- Shared package titan_pkg:
  - State encoding localparams: IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2.
  - Grant ID constants: GNT_I = 1'b0, GNT_D = 1'b1.
- One natural sub-module, titan_bus_watchdog: counter with clear, enable and expire output.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Reset held low 5 cycles:
  - All outputs 0 throughout.
  - After release with no requests, m_cyc stays 0.
- d_req, d_we = 1, d_addr = 0, d_wdata = 7, d_sel = 4'hF, with memory acking 2 cycles after m_cyc:
  - m_addr = 0, m_wdata = 7, m_we = 1.
  - One d_ack pulse; i_ack/i_err stay 0.
- Load from address 0 after the store above:
  - d_ack with d_rdata = 7.
  - Exactly one IDLE cycle between the two transactions.
- i_req and d_req asserted together continuously at addresses 0x10 and 0x20:
  - Grant order D, I, D, I, ...
  - m_addr alternates 0x20, 0x10.
  - Each requester is acked once per pair.
- Memory never acks, TIMEOUT = 4:
  - d_err pulse exactly 4 BUSY cycles after m_cyc rises; m_cyc drops.
  - A late m_ack is ignored; the next i_req is serviced normally.
- rst driven low while BUSY_D:
  - Next cycle m_cyc = 0, no d_ack or d_err.
  - A subsequent stray m_ack is ignored.

Source files
------------

// File: rtl/titan_pkg.sv
// Shared types and constants for the titan memory arbiter.
// Holds the FSM encoding, grant IDs and the watchdog counter sizing.
package titan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_e;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   function automatic int unsigned cnt_width(input int unsigned t);
      int unsigned w;
      w = $clog2(t + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/titan_bus_watchdog.sv
// Bus watchdog: counts stalled BUSY cycles and flags expiry.
// TIMEOUT of zero leaves expire_o permanently low.
module titan_bus_watchdog
   import titan_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW     = cnt_width(TIMEOUT);
   localparam int unsigned LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expire_o = (TIMEOUT != 0) && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/titan_mem_arbiter.sv
// Round-robin arbiter sharing one BRAM port between fetch and LSU.
// The bus is driven only from registered copies of the winner's request.
module titan_mem_arbiter
   import titan_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ack,
   output logic                i_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_sel,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                d_err,
   output logic                m_cyc,
   output logic                m_we,
   output logic [DATA_W/8-1:0] m_sel,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ack
);

   localparam int unsigned SEL_W = DATA_W / 8;

   state_e              state_q;
   logic                last_q;
   logic                m_cyc_q;
   logic                m_we_q;
   logic [SEL_W-1:0]    m_sel_q;
   logic [ADDR_W-1:0]   m_addr_q;
   logic [DATA_W-1:0]   m_wdata_q;
   logic                i_ack_q;
   logic                i_err_q;
   logic                d_ack_q;
   logic                d_err_q;
   logic [DATA_W-1:0]   i_rdata_q;
   logic [DATA_W-1:0]   d_rdata_q;

   logic any_req;
   logic pick_d;
   logic busy;
   logic wd_expire;

   assign any_req = i_req | d_req;
   // On contention the side that did not win last time goes next.
   assign pick_d  = d_req & (~i_req | (last_q == GNT_I));
   assign busy    = (state_q != IDLE);

   titan_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (~busy),
      .en_i     (busy & ~m_ack),
      .expire_o (wd_expire)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         last_q    <= GNT_I;
         m_cyc_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_sel_q   <= '0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         i_ack_q   <= 1'b0;
         i_err_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         d_err_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         i_ack_q <= 1'b0;
         i_err_q <= 1'b0;
         d_ack_q <= 1'b0;
         d_err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  m_cyc_q <= 1'b1;
                  if (pick_d) begin
                     m_we_q    <= d_we;
                     m_sel_q   <= d_sel;
                     m_addr_q  <= d_addr;
                     m_wdata_q <= d_wdata;
                     last_q    <= GNT_D;
                     state_q   <= BUSY_D;
                  end else begin
                     m_we_q    <= 1'b0;
                     m_sel_q   <= '1;
                     m_addr_q  <= i_addr;
                     m_wdata_q <= '0;
                     last_q    <= GNT_I;
                     state_q   <= BUSY_I;
                  end
               end
            end
            BUSY_I, BUSY_D: begin
               // A completion in the expiry cycle still counts as an ack.
               if (m_ack) begin
                  m_cyc_q <= 1'b0;
                  m_we_q  <= 1'b0;
                  state_q <= IDLE;
                  if (state_q == BUSY_D) begin
                     d_ack_q   <= 1'b1;
                     d_rdata_q <= m_rdata;
                  end else begin
                     i_ack_q   <= 1'b1;
                     i_rdata_q <= m_rdata;
                  end
               end else if (wd_expire) begin
                  m_cyc_q <= 1'b0;
                  m_we_q  <= 1'b0;
                  state_q <= IDLE;
                  if (state_q == BUSY_D) begin
                     d_err_q <= 1'b1;
                  end else begin
                     i_err_q <= 1'b1;
                  end
               end
            end
            default: begin
               m_cyc_q <= 1'b0;
               m_we_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m_cyc   = m_cyc_q;
   assign m_we    = m_we_q;
   assign m_sel   = m_sel_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign i_ack   = i_ack_q;
   assign i_err   = i_err_q;
   assign i_rdata = i_rdata_q;
   assign d_ack   = d_ack_q;
   assign d_err   = d_err_q;
   assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_titan_mem_arbiter.sv
// Self-checking bench for titan_mem_arbiter.
// Directed vectors, hand sequences, then random traffic vs a model.
module tb_titan_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          i_err;
   logic          d_req;
   logic          d_we;
   logic [SW-1:0] d_sel;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          d_err;
   logic          m_cyc;
   logic          m_we;
   logic [SW-1:0] m_sel;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;

   titan_mem_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_req   (i_req),
      .i_addr  (i_addr),
      .i_rdata (i_rdata),
      .i_ack   (i_ack),
      .i_err   (i_err),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_sel   (d_sel),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_rdata (d_rdata),
      .d_ack   (d_ack),
      .d_err   (d_err),
      .m_cyc   (m_cyc),
      .m_we    (m_we),
      .m_sel   (m_sel),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata),
      .m_ack   (m_ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];
   bit          auto_mem = 1'b0;
   bit          rand_lat = 1'b0;
   int          mem_lat  = 0;
   int          cyc_cnt  = 0;

   typedef struct {
      logic        ireq;
      logic        dreq;
      logic        ack;
      logic [31:0] rd;
      logic        cyc;
      logic [31:0] addr;
      logic        iack;
      logic        dack;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Simple BRAM model answering mem_lat cycles after m_cyc is seen.
   task automatic mem_step();
      m_ack = 1'b0;
      if (m_cyc) begin
         if (cyc_cnt >= mem_lat) begin
            m_ack   = 1'b1;
            m_rdata = mem[m_addr[5:2]];
            if (m_we) begin
               for (int b = 0; b < 4; b++) begin
                  if (m_sel[b]) mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
               end
            end
            cyc_cnt = 0;
            if (rand_lat) mem_lat = $urandom_range(0, 3);
         end else begin
            cyc_cnt++;
         end
      end else begin
         cyc_cnt = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_mem) mem_step();
   endtask

   function automatic logic sig(input int w);
      case (w)
         0:       return m_cyc;
         1:       return i_ack;
         default: return d_ack;
      endcase
   endfunction

   task automatic wait_for(input int w, input int bound, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!sig(w) && n < bound);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      for (int k = 0; k < n; k++) tick();
      rst = 1'b1;
   endtask

   int  n;
   bit  si, sd, sa;
   bit  ei, ed;
   bit  mdl_busy;
   bit  mdl_owner;
   bit  mdl_last;
   bit  win;

   initial begin
      rst = 1'b0;
      i_req = 1'b1; i_addr = 32'h44;
      d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF;
      d_addr = 32'h48; d_wdata = 32'hDEAD;
      m_rdata = 32'h5A5A; m_ack = 1'b1;
      for (int k = 0; k < 16; k++) mem[k] = '0;

      // Reset held for 5 cycles with busy inputs.
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rst_ctl", {m_cyc, m_we, i_ack, i_err, d_ack, d_err, m_sel}, 0);
         chk("rst_bus", {m_addr, m_wdata}, 0);
         chk("rst_rd", {i_rdata, d_rdata}, 0);
      end
      i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("idle_cyc", m_cyc, 0);
      end

      // Store then load at address 0.
      auto_mem = 1'b1; mem_lat = 2;
      d_req = 1'b1; d_we = 1'b1; d_addr = 0; d_wdata = 7; d_sel = 4'hF;
      wait_for(0, 10, n);
      chk("st_cyc", m_cyc, 1);
      chk("st_addr", m_addr, 0);
      chk("st_wdata", m_wdata, 7);
      chk("st_we", m_we, 1);
      chk("st_sel", m_sel, 4'hF);
      wait_for(2, 10, n);
      chk("st_ack", d_ack, 1);
      chk("st_lat", n, 3);
      chk("st_iside", {i_ack, i_err, d_err}, 0);
      chk("gap_cyc", m_cyc, 0);
      d_we = 1'b0;
      tick();
      chk("ld_cyc", m_cyc, 1);
      chk("ld_we", m_we, 0);
      chk("st_pulse", d_ack, 0);
      wait_for(2, 10, n);
      chk("ld_ack", d_ack, 1);
      chk("ld_rdata", d_rdata, 7);
      d_req = 1'b0;
      tick();
      chk("ld_done", {m_cyc, d_ack}, 0);
      auto_mem = 1'b0;

      // Contention, manual memory responses.
      do_reset(1);
      i_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0;
      tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 32'hA1, 1'b0, 32'h0,  1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 32'hB2, 1'b0, 32'h0,  1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 32'hC3, 1'b0, 32'h0,  1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 32'hD4, 1'b0, 32'h0,  1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 1'b1, 32'hEE, 1'b0, 32'h0,  1'b0, 1'b0};
      for (int k = 0; k < 10; k++) begin
         i_req = tbl[k].ireq; d_req = tbl[k].dreq;
         m_ack = tbl[k].ack;  m_rdata = tbl[k].rd;
         tick();
         chk($sformatf("tbl%0d_cyc", k), m_cyc, tbl[k].cyc);
         if (tbl[k].cyc) chk($sformatf("tbl%0d_addr", k), m_addr, tbl[k].addr);
         chk($sformatf("tbl%0d_iack", k), i_ack, tbl[k].iack);
         chk($sformatf("tbl%0d_dack", k), d_ack, tbl[k].dack);
         if (tbl[k].iack) chk($sformatf("tbl%0d_ird", k), i_rdata, tbl[k].rd);
         if (tbl[k].dack) chk($sformatf("tbl%0d_drd", k), d_rdata, tbl[k].rd);
      end
      m_ack = 1'b0;

      // Memory never answers: watchdog fires after TO busy cycles.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 5;
      wait_for(0, 10, n);
      chk("to_cyc", m_cyc, 1);
      n = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (!m_cyc) break;
         n++;
      end
      chk("to_len", n, TO);
      chk("to_err", {d_err, d_ack, i_err}, 3'b100);
      d_req = 1'b0;
      m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      chk("late_ack", {m_cyc, i_ack, d_ack, d_err}, 0);
      tick();
      chk("late_ack2", {m_cyc, i_ack, d_ack}, 0);
      auto_mem = 1'b1; mem_lat = 0;
      i_req = 1'b1; i_addr = 32'h0;
      wait_for(1, 10, n);
      chk("post_to_iack", i_ack, 1);
      chk("post_to_ird", i_rdata, 7);
      chk("post_to_ierr", i_err, 0);
      i_req = 1'b0;
      tick();
      auto_mem = 1'b0;

      // Reset while a data transaction is open.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
      wait_for(0, 10, n);
      chk("rb_cyc", m_cyc, 1);
      tick();
      rst = 1'b0;
      tick();
      chk("rb_abort", {m_cyc, d_ack, d_err}, 0);
      rst = 1'b1; d_req = 1'b0; m_ack = 1'b1;
      tick();
      m_ack = 1'b0;
      chk("rb_stray", {m_cyc, d_ack, d_err}, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rb_quiet", {m_cyc, d_ack, d_err, i_ack, i_err}, 0);
      end

      // Random traffic against a transaction-level model.
      for (int k = 0; k < 16; k++) begin
         mem[k] = '0;
         ref_mem[k] = '0;
      end
      auto_mem = 1'b1; rand_lat = 1'b1; mem_lat = $urandom_range(0, 3);
      mdl_busy = 1'b0; mdl_owner = 1'b0; mdl_last = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         si = i_req; sd = d_req; sa = m_ack;
         tick();
         ei = 1'b0; ed = 1'b0;
         if (mdl_busy) begin
            if (sa) begin
               mdl_busy = 1'b0;
               if (mdl_owner) begin
                  ed = 1'b1;
                  if (!d_we) begin
                     chk("rnd_drd", d_rdata, ref_mem[d_addr[5:2]]);
                  end else begin
                     for (int b = 0; b < 4; b++) begin
                        if (d_sel[b]) ref_mem[d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
                     end
                  end
               end else begin
                  ei = 1'b1;
                  chk("rnd_ird", i_rdata, ref_mem[i_addr[5:2]]);
               end
               chk("rnd_done_cyc", m_cyc, 0);
            end else begin
               chk("rnd_busy_cyc", m_cyc, 1);
            end
         end else if (si || sd) begin
            win = sd && (!si || !mdl_last);
            mdl_busy = 1'b1; mdl_owner = win; mdl_last = win;
            chk("rnd_gnt_cyc", m_cyc, 1);
            chk("rnd_gnt_addr", m_addr, win ? d_addr : i_addr);
            chk("rnd_gnt_we", m_we, win ? d_we : 1'b0);
            chk("rnd_gnt_sel", m_sel, win ? d_sel : 4'hF);
            if (win && d_we) chk("rnd_gnt_wd", m_wdata, d_wdata);
         end else begin
            chk("rnd_idle_cyc", m_cyc, 0);
         end
         chk("rnd_iack", i_ack, ei);
         chk("rnd_dack", d_ack, ed);
         chk("rnd_err", {i_err, d_err}, 0);
         if (ei) i_req = 1'b0;
         if (ed) d_req = 1'b0;
         if (!i_req && !ei && $urandom_range(0, 2) == 0) begin
            i_req = 1'b1;
            i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         end
         if (!d_req && !ed && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1;
            d_we = 1'($urandom_range(0, 1));
            d_sel = 4'($urandom_range(1, 15));
            d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            d_wdata = $urandom;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
